// File: rtl/pixel_write_queue.sv
// Pixel-plot FIFO feeding framebuffer writes over a valid/ready port, with a full-screen clear sweep.
// Optional macro PIXEL_BOUNDS_CHECK_EN discards off-screen pixels and counts them on oDropCount.
module pixel_write_queue #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int FIFO_DEPTH      = 8,
    parameter int ADDR_WIDTH      = 15
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [7:0]            iX,
    input  logic [6:0]            iY,
    input  logic [2:0]            iColour,
    input  logic                  iPlot,
    input  logic                  iClear,
    input  logic [2:0]            iClearColour,
    input  logic                  iMemReady,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [2:0]            oMemData,
    output logic                  oMemWe,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oOverflow,
    output logic [7:0]            oDropCount,
    output logic                  oClearDone
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);

    typedef enum logic {
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    logic                    clear_pending_q, clear_pending_d;
    logic                    clear_done_q, clear_done_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic [2:0]              clear_colour_q, clear_colour_d;

    logic [ADDR_WIDTH-1:0]   fifo_addr_q   [FIFO_DEPTH];
    logic [2:0]              fifo_colour_q [FIFO_DEPTH];

    logic                    accept;
    logic                    store;
    logic                    pop;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   push_addr;

    assign push_addr = ADDR_WIDTH'(32'(iY) * 32'(X_SCREEN_PIXELS) + 32'(iX));

`ifdef PIXEL_BOUNDS_CHECK_EN
    assign in_range = ({24'd0, iX} < 32'(X_SCREEN_PIXELS)) && ({25'd0, iY} < 32'(Y_SCREEN_PIXELS));
`else
    assign in_range = 1'b1;
`endif

    // Space is judged on the pre-edge count, so a same-edge pop never frees a slot for the push.
    assign accept = iPlot && (count_q < DEPTH_C);
    assign store  = accept && in_range;
    assign pop    = (state_q == ST_DRAIN) && !empty_q && iMemReady;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == DEPTH_C);
        empty_d    = (count_d == '0);
        overflow_d = overflow_q || (iPlot && !accept);
    end

    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        clear_colour_d  = clear_colour_q;
        sweep_d         = sweep_q;
        clear_done_d    = 1'b0;
        if (iClear && !clear_pending_q && (state_q == ST_DRAIN)) begin
            clear_pending_d = 1'b1;
            clear_colour_d  = iClearColour;
        end
        case (state_q)
            ST_DRAIN: begin
                // Wait for the in-flight head write to complete before sweeping.
                if (clear_pending_q && (empty_q || pop)) begin
                    state_d         = ST_CLEAR;
                    clear_pending_d = 1'b0;
                    sweep_d         = '0;
                end
            end
            ST_CLEAR: begin
                if (iMemReady) begin
                    if (sweep_q == LAST_ADDR) begin
                        state_d      = ST_DRAIN;
                        clear_done_d = 1'b1;
                    end else begin
                        sweep_d = sweep_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_DRAIN;
        endcase
    end

    always_comb begin
        oMemWe   = 1'b0;
        oMemAddr = '0;
        oMemData = '0;
        if (state_q == ST_CLEAR) begin
            oMemWe   = 1'b1;
            oMemAddr = sweep_q;
            oMemData = clear_colour_q;
        end else if (!empty_q) begin
            oMemWe   = 1'b1;
            oMemAddr = fifo_addr_q[rd_ptr_q];
            oMemData = fifo_colour_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q         <= ST_DRAIN;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            full_q          <= 1'b0;
            empty_q         <= 1'b1;
            overflow_q      <= 1'b0;
            clear_pending_q <= 1'b0;
            clear_done_q    <= 1'b0;
            sweep_q         <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            full_q          <= full_d;
            empty_q         <= empty_d;
            overflow_q      <= overflow_d;
            clear_pending_q <= clear_pending_d;
            clear_done_q    <= clear_done_d;
            sweep_q         <= sweep_d;
        end
    end

    // Queue storage and fill colour carry data only; validity comes from the pointers and state.
    always_ff @(posedge clk) begin
        clear_colour_q <= clear_colour_d;
        if (store) begin
            fifo_addr_q[wr_ptr_q]   <= push_addr;
            fifo_colour_q[wr_ptr_q] <= iColour;
        end
    end

`ifdef PIXEL_BOUNDS_CHECK_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (accept && !in_range && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign oDropCount = drop_count_q;
`else
    assign oDropCount = 8'd0;
`endif

    assign oFull      = full_q;
    assign oEmpty     = empty_q;
    assign oOverflow  = overflow_q;
    assign oClearDone = clear_done_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Scoreboard bench for pixel_write_queue: a queue-based reference model predicts every memory
// write and flag, a negedge monitor compares what the DUT presents and accepts.
module tb_pixel_write_queue;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  iX = '0;
    logic [6:0]  iY = '0;
    logic [2:0]  iColour = '0;
    logic        iPlot = 1'b0;
    logic        iClear = 1'b0;
    logic [2:0]  iClearColour = '0;
    logic        iMemReady = 1'b0;
    logic [14:0] oMemAddr;
    logic [2:0]  oMemData;
    logic        oMemWe;
    logic        oFull;
    logic        oEmpty;
    logic        oOverflow;
    logic [7:0]  oDropCount;
    logic        oClearDone;

    always #5 clk = ~clk;

    pixel_write_queue dut (
        .clk          (clk),
        .Reset        (Reset),
        .iX           (iX),
        .iY           (iY),
        .iColour      (iColour),
        .iPlot        (iPlot),
        .iClear       (iClear),
        .iClearColour (iClearColour),
        .iMemReady    (iMemReady),
        .oMemAddr     (oMemAddr),
        .oMemData     (oMemData),
        .oMemWe       (oMemWe),
        .oFull        (oFull),
        .oEmpty       (oEmpty),
        .oOverflow    (oOverflow),
        .oDropCount   (oDropCount),
        .oClearDone   (oClearDone)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];

    // Reference model: queued pixels as {addr, colour}, plus clear-sweep bookkeeping.
    logic [17:0] mq[$];
    bit          m_clear = 0;
    bit          m_pending = 0;
    bit          m_ovf = 0;
    bit          m_done = 0;
    bit          started = 0;
    int          m_sweep = 0;
    int          m_drop = 0;
    logic [2:0]  m_ccol = '0;

    always @(posedge clk) begin : model
        bit          pres, acc, popped, start, was_clear, done_n;
        int          old_size;
        logic [17:0] pw;
        old_size  = mq.size();
        was_clear = m_clear;
        pres      = m_clear || (old_size > 0);
        pw        = m_clear ? {m_sweep[14:0], m_ccol} : ((old_size > 0) ? mq[0] : 18'd0);
        acc       = pres && (iMemReady === 1'b1);
        if (started && acc) exp_q.push_back(pw);
        if (Reset) begin
            mq.delete();
            m_clear   = 0;
            m_pending = 0;
            m_ovf     = 0;
            m_done    = 0;
            m_drop    = 0;
            m_sweep   = 0;
            started   = 1;
        end else begin
            popped = !was_clear && acc;
            start  = !was_clear && m_pending && ((old_size == 0) || popped);
            done_n = 0;
            if (was_clear && iMemReady) begin
                if (m_sweep == 160 * 120 - 1) begin
                    m_clear = 0;
                    done_n  = 1;
                end else begin
                    m_sweep++;
                end
            end
            if (popped) void'(mq.pop_front());
            if (iPlot) begin
                if (old_size >= 8) begin
                    m_ovf = 1;
                end else begin
`ifdef PIXEL_BOUNDS_CHECK_EN
                    if ((iX >= 8'd160) || (iY >= 7'd120)) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        mq.push_back({15'(int'(iY) * 160 + int'(iX)), iColour});
                    end
`else
                    mq.push_back({15'(int'(iY) * 160 + int'(iX)), iColour});
`endif
                end
            end
            if (iClear && !m_pending && !was_clear) begin
                m_pending = 1;
                m_ccol    = iClearColour;
            end
            if (start) begin
                m_clear   = 1;
                m_sweep   = 0;
                m_pending = 0;
            end
            m_done = done_n;
        end
    end

    always @(negedge clk) begin : monitor
        logic [17:0] e, o;
        bit          m_we;
        logic [14:0] ea;
        logic [2:0]  ed;
        if (started) begin
            while ((obs_q.size() > 0) && (exp_q.size() > 0)) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL write_order: got addr %0d data %0d, expected addr %0d data %0d",
                             o[17:3], o[2:0], e[17:3], e[2:0]);
                end
            end
            m_we = m_clear || (mq.size() > 0);
            ea   = m_clear ? m_sweep[14:0] : ((mq.size() > 0) ? mq[0][17:3] : 15'd0);
            ed   = m_clear ? m_ccol : ((mq.size() > 0) ? mq[0][2:0] : 3'd0);
            vectors++;
            if ({oMemWe, oMemAddr, oMemData, oFull, oEmpty, oOverflow, oClearDone, oDropCount} !==
                {m_we, ea, ed, (mq.size() == 8), (mq.size() == 0), m_ovf, m_done, 8'(m_drop)}) begin
                miscompares++;
                $display("FAIL cycle_outputs @%0t: we/addr/data/full/empty/ovf/done/drop got %b/%0d/%0d/%b/%b/%b/%b/%0d, expected %b/%0d/%0d/%b/%b/%b/%b/%0d",
                         $time, oMemWe, oMemAddr, oMemData, oFull, oEmpty, oOverflow, oClearDone, oDropCount,
                         m_we, ea, ed, (mq.size() == 8), (mq.size() == 0), m_ovf, m_done, m_drop);
            end
            if ((oMemWe === 1'b1) && (iMemReady === 1'b1)) obs_q.push_back({oMemAddr, oMemData});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input int x, input int y, input int c);
        iPlot   = 1'b1;
        iX      = 8'(x);
        iY      = 7'(y);
        iColour = 3'(c);
        step();
        iPlot   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        int n = 0;
        while ((oClearDone !== 1'b1) && (n < budget)) begin
            if (rnd_ready) iMemReady = ($urandom_range(0, 2) != 0);
            step();
            n++;
        end
        vectors++;
        if (oClearDone !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_done_wait: oClearDone=%b after %0d cycles, required 1", oClearDone, n);
        end
    endtask

    initial begin
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();

        // Basic write, then off-screen coordinates written with truncated linear address
        iMemReady = 1'b1;
        push1(3, 2, 5);
        repeat (3) step();
        push1(160, 0, 3);
        push1(0, 120, 4);
        repeat (3) step();

        // Backpressure: 4x4 box into a stalled port overflows the 8-entry queue
        iMemReady = 1'b0;
        for (int by = 0; by < 4; by++) begin
            for (int bx = 0; bx < 4; bx++) begin
                push1(10 + bx, 20 + by, (bx + by) % 8);
            end
        end
        repeat (3) step();
        iMemReady = 1'b1;
        repeat (12) step();

        // Clear behind two queued pixels
        iMemReady = 1'b0;
        push1(5, 5, 1);
        push1(6, 5, 2);
        iMemReady    = 1'b1;
        iClear       = 1'b1;
        iClearColour = 3'd0;
        step();
        iClear = 1'b0;
        wait_done(19300, 1'b0);
        repeat (3) step();

        // Clear with a stalling port and pixels pushed mid-sweep
        iClearColour = 3'd6;
        iClear       = 1'b1;
        step();
        iClear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iMemReady = ($urandom_range(0, 2) != 0);
            push1(40 + k, 7, k + 1);
        end
        wait_done(40000, 1'b1);
        iMemReady = 1'b1;
        repeat (6) step();

        // Reset in the middle of a sweep
        iClearColour = 3'd3;
        iClear       = 1'b1;
        step();
        iClear = 1'b0;
        push1(1, 2, 3);
        push1(4, 5, 6);
        begin
            int n = 0;
            while (!((oMemWe === 1'b1) && (oMemAddr === 15'd500)) && (n < 1000)) begin
                step();
                n++;
            end
            vectors++;
            if (oMemAddr !== 15'd500) begin
                miscompares++;
                $display("FAIL sweep_reach_500: oMemAddr=%0d after %0d cycles, required 500", oMemAddr, n);
            end
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        push1(1, 1, 7);
        repeat (4) step();

        // Randomised traffic with stall bursts
        for (int i = 0; i < 400; i++) begin
            iPlot     = ($urandom_range(0, 1) != 0);
            iX        = 8'($urandom_range(0, 165));
            iY        = 7'($urandom_range(0, 123));
            iColour   = 3'($urandom_range(0, 7));
            iMemReady = ((i % 50) < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
        end
        iPlot     = 1'b0;
        iMemReady = 1'b1;
        repeat (20) step();
        @(negedge clk);
        #1;
        vectors++;
        if ((exp_q.size() != 0) || (obs_q.size() != 0)) begin
            miscompares++;
            $display("FAIL leftover_writes: %0d expected and %0d observed writes unmatched, required 0 and 0",
                     exp_q.size(), obs_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
